// File: rtl/vpd_regfile_if.sv
// vpd_regfile_if: cfg_vpd request bus between the host_if master and the VPD register file.
interface vpd_regfile_if;
    logic [14:0] cfg_vpd_addr;
    logic        cfg_vpd_wren;
    logic [31:0] cfg_vpd_wdata;
    logic        cfg_vpd_rden;
    logic [31:0] vpd_cfg_rdata;
    logic        vpd_cfg_done;
    logic        vpd_err_unimplemented_addr;
    modport master (
        output cfg_vpd_addr, cfg_vpd_wren, cfg_vpd_wdata, cfg_vpd_rden,
        input  vpd_cfg_rdata, vpd_cfg_done, vpd_err_unimplemented_addr
    );
    modport slave (
        input  cfg_vpd_addr, cfg_vpd_wren, cfg_vpd_wdata, cfg_vpd_rden,
        output vpd_cfg_rdata, vpd_cfg_done, vpd_err_unimplemented_addr
    );
endinterface

// File: rtl/vpd_regfile.sv
// vpd_regfile: VPD word RAM serving held-level cfg_vpd requests; VPD_WRITE_LOCK_EN adds a sticky write lock.
module vpd_regfile #(
    parameter int          VPD_WORDS  = 256,
    parameter logic [31:0] INIT_VALUE = 32'h0000_0000
) (
    input logic          clock_tlx,
    input logic          reset_afu_n,
    vpd_regfile_if.slave bus
);
    localparam int AW = $clog2(VPD_WORDS);
    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_DONE, WR_DONE, ERR_DONE, RELEASE} state_t;
    state_t        state, state_nxt;
    logic [31:0]   mem [VPD_WORDS] = '{default: INIT_VALUE};
    logic [AW-1:0] idx, idx_q;
    logic [31:0]   rdata_q, rd_word;
    logic          req, accept, bad, do_wr;
    assign req    = bus.cfg_vpd_rden | bus.cfg_vpd_wren;
    assign accept = state == IDLE && req;
    assign idx    = bus.cfg_vpd_addr[AW+1:2];
    // upper address bits are checked, not aliased
    assign bad    = bus.cfg_vpd_addr[1:0] != 2'b00 || int'(bus.cfg_vpd_addr[14:2]) >= VPD_WORDS ||
                    (bus.cfg_vpd_rden && bus.cfg_vpd_wren);
`ifdef VPD_WRITE_LOCK_EN
    logic lock, wr_drop_q;
    assign do_wr   = accept && !bad && bus.cfg_vpd_wren && !lock;
    assign rd_word = idx_q == '1 ? {31'b0, lock} : mem[idx_q];
    assign bus.vpd_err_unimplemented_addr = state == ERR_DONE || (state == WR_DONE && wr_drop_q);
    always_ff @(posedge clock_tlx) begin
        if (!reset_afu_n) begin
            lock      <= 1'b0;
            wr_drop_q <= 1'b0;
        end else begin
            if (do_wr && idx == '1 && bus.cfg_vpd_wdata == 32'hA5A5_0001) lock <= 1'b1;
            if (accept) wr_drop_q <= lock;
        end
    end
`else
    assign do_wr   = accept && !bad && bus.cfg_vpd_wren;
    assign rd_word = mem[idx_q];
    assign bus.vpd_err_unimplemented_addr = state == ERR_DONE;
`endif
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:                       if (req) state_nxt = bad ? ERR_DONE : bus.cfg_vpd_wren ? WR_DONE : RD_ISSUE;
            RD_ISSUE:                   state_nxt = RD_DONE;
            RD_DONE, WR_DONE, ERR_DONE: state_nxt = RELEASE;
            RELEASE:                    if (!req) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clock_tlx) begin
        if (!reset_afu_n) begin
            state   <= IDLE;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) idx_q <= idx;
            if (state_nxt == ERR_DONE) rdata_q <= '0;
            else if (state == RD_ISSUE) rdata_q <= rd_word;
        end
    end
    always_ff @(posedge clock_tlx)
        if (reset_afu_n && do_wr) mem[idx] <= bus.cfg_vpd_wdata;
    assign bus.vpd_cfg_rdata = rdata_q;
    assign bus.vpd_cfg_done  = state inside {RD_DONE, WR_DONE, ERR_DONE};
endmodule
